regfile_wb_queue: RTL and testbench

//   Write-side feeder for the 32x32 register file: collects writeback results from the ALU
//   and load paths, queues them in a small FIFO and retires one per cycle onto the regfile

---
 rtl/regfile_wb_queue_if.sv | 34 +++
 rtl/regfile_wb_queue.sv | 88 ++++++++
 tb/tb_regfile_wb_queue.sv | 139 +++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_if.sv
// regfile_wb_queue_if: request, retire and scoreboard-query bundle for regfile_wb_queue.
// master = producer/decode side, slave = the queue.
interface regfile_wb_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                     Flush;
    logic                     LdValid;
    logic                     LdReady;
    logic [ADDR_W-1:0]        LdAddr;
    logic [DATA_W-1:0]        LdData;
    logic                     AluValid;
    logic                     AluReady;
    logic [ADDR_W-1:0]        AluAddr;
    logic [DATA_W-1:0]        AluData;
    logic [ADDR_W-1:0]        WrAddr;
    logic [DATA_W-1:0]        WrData;
    logic                     WrEnable;
    logic [ADDR_W-1:0]        QAddr;
    logic                     QPending;
    logic [DATA_W-1:0]        QData;
    logic [$clog2(DEPTH):0]   Count;

    modport master (
        output Flush, LdValid, LdAddr, LdData, AluValid, AluAddr, AluData, QAddr,
        input  LdReady, AluReady, WrAddr, WrData, WrEnable, QPending, QData, Count
    );

    modport slave (
        input  Flush, LdValid, LdAddr, LdData, AluValid, AluAddr, AluData, QAddr,
        output LdReady, AluReady, WrAddr, WrData, WrEnable, QPending, QData, Count
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: queues load/ALU writeback results and retires one per cycle to the regfile.
// Define REGFILE_WB_FWD_EN to forward the youngest matching queued value on QData.
module regfile_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic              Clk,
    input logic              Rst_n,
    regfile_wb_queue_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    logic [IW:0]        r_wr_ptr;
    logic [IW:0]        r_rd_ptr;
    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];

    logic               w_full;
    logic               w_empty;
    logic [IW:0]        w_count;
    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_push_addr;
    logic [DATA_W-1:0]  w_push_data;
    logic [IW-1:0]      w_slot [DEPTH];
    logic [DEPTH-1:0]   w_hit;
    logic [DATA_W-1:0]  w_qdata;

    assign w_full      = (r_wr_ptr[IW] != r_rd_ptr[IW]) && (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);
    assign w_empty     = r_wr_ptr == r_rd_ptr;
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_ready     = !w_full && !bus.Flush;
    assign w_push_addr = bus.LdValid ? bus.LdAddr : bus.AluAddr;
    assign w_push_data = bus.LdValid ? bus.LdData : bus.AluData;
    // Writes to $0 complete the handshake but never occupy a slot.
    assign w_push      = w_ready && (bus.LdValid || bus.AluValid) && (w_push_addr != '0);
    assign w_pop       = !w_empty;

    assign bus.LdReady  = w_ready;
    assign bus.AluReady = w_ready && !bus.LdValid;
    assign bus.WrEnable = !w_empty;
    assign bus.WrAddr   = w_empty ? '0 : r_addr[r_rd_ptr[IW-1:0]];
    assign bus.WrData   = w_empty ? '0 : r_data[r_rd_ptr[IW-1:0]];
    assign bus.Count    = w_count;
    assign bus.QPending = |w_hit;
    assign bus.QData    = w_qdata;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (bus.Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + {{IW{1'b0}}, w_push};
            r_rd_ptr <= r_rd_ptr + {{IW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr[IW-1:0]] <= w_push_addr;
            r_data[r_wr_ptr[IW-1:0]] <= w_push_data;
        end
    end

    // Slots indexed by age: k = 0 is the head (oldest).
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_slot[k] = r_rd_ptr[IW-1:0] + IW'(k);
            w_hit[k]  = ((IW+1)'(k) < w_count) && (r_addr[w_slot[k]] == bus.QAddr) && (bus.QAddr != '0);
        end
    end

`ifdef REGFILE_WB_FWD_EN
    // Later (younger) hits override earlier ones.
    always_comb begin
        w_qdata = '0;
        for (int k = 0; k < DEPTH; k++)
            if (w_hit[k]) w_qdata = r_data[w_slot[k]];
    end
`else
    assign w_qdata = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed + random stimulus against a queue-based model of the writeback queue.
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    wr_t  q[$];

    regfile_wb_queue_if #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) bus ();
    regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input bit fl);
        logic        pend;
        logic [31:0] fwd;
        bit          rdy;
        pend = 1'b0;
        fwd  = '0;
        foreach (q[i])
            if (bus.QAddr != 0 && q[i].a == bus.QAddr) begin
                pend = 1'b1;
                fwd  = q[i].d;
            end
`ifndef REGFILE_WB_FWD_EN
        fwd = '0;
`endif
        rdy = (q.size() < DEPTH) && !fl;
        chk("LdReady",  bus.LdReady,  rdy);
        chk("AluReady", bus.AluReady, rdy && !bus.LdValid);
        chk("WrEnable", bus.WrEnable, q.size() != 0);
        chk("WrAddr",   bus.WrAddr,   q.size() ? q[0].a : 5'd0);
        chk("WrData",   bus.WrData,   q.size() ? q[0].d : 32'd0);
        chk("QPending", bus.QPending, pend);
        chk("QData",    bus.QData,    fwd);
        chk("Count",    bus.Count,    q.size());
    endtask

    // One clock cycle: drive, check combinational outputs, then advance the model past the edge.
    task automatic step(input bit fl, input bit lv, input logic [4:0] la, input logic [31:0] ld,
                        input bit av, input logic [4:0] aa, input logic [31:0] ad, input logic [4:0] qa);
        bit rdy;
        @(negedge Clk);
        bus.Flush = fl; bus.LdValid = lv; bus.LdAddr = la; bus.LdData = ld;
        bus.AluValid = av; bus.AluAddr = aa; bus.AluData = ad; bus.QAddr = qa;
        #1;
        check_outputs(fl);
        rdy = (q.size() < DEPTH) && !fl;
        if (fl) q.delete();
        else begin
            if (q.size()) void'(q.pop_front());
            if (rdy && lv && la != 0) q.push_back('{la, ld});
            else if (rdy && !lv && av && aa != 0) q.push_back('{aa, ad});
        end
    endtask

    task automatic idle(input logic [4:0] qa);
        step(0, 0, 0, 0, 0, 0, 0, qa);
    endtask

    initial begin
        bus.Flush = 0; bus.LdValid = 0; bus.LdAddr = 0; bus.LdData = 0;
        bus.AluValid = 0; bus.AluAddr = 0; bus.AluData = 0; bus.QAddr = 0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        idle(0);
        // single ALU write retires next cycle, then queue empties
        step(0, 0, 0, 0, 1, 5'd3, 32'hDEAD, 3);
        idle(3);
        chk("t1_addr", bus.WrAddr, 5'd3);
        chk("t1_data", bus.WrData, 32'hDEAD);
        idle(3);
        // load wins over ALU in the same cycle
        step(0, 1, 5'd4, 32'h44, 1, 5'd5, 32'h55, 0);
        chk("t2_alu_ready_low", bus.AluReady, 1'b0);
        step(0, 0, 0, 0, 1, 5'd5, 32'h55, 0);
        chk("t2_first_retire", bus.WrAddr, 5'd4);
        idle(0);
        chk("t2_second_retire", bus.WrAddr, 5'd5);
        // back-to-back pushes with alternating sources: occupancy stays at one, pointers wrap
        for (int i = 0; i < 3 * DEPTH; i++)
            step(0, i[0], 5'(i + 1), 32'(i * 7), !i[0], 5'(i + 9), 32'(i * 13), 5'(i + 1));
        idle(0);
        idle(0);
        // address 0 is accepted but dropped
        step(0, 0, 0, 0, 1, 5'd0, 32'h1234, 0);
        idle(0);
        chk("t4_no_write", bus.WrEnable, 1'b0);
        // same-address writes and scoreboard query
        step(0, 0, 0, 0, 1, 5'd7, 32'h11, 7);
        step(0, 0, 0, 0, 1, 5'd7, 32'h22, 7);
        idle(7);
        idle(0);
        // flush discards queued entry and concurrent load
        step(0, 0, 0, 0, 1, 5'd9, 32'h99, 9);
        step(1, 1, 5'd10, 32'hAA, 0, 0, 0, 9);
        idle(10);
        chk("t6_flush_empty", bus.Count, 0);
        // asynchronous reset mid-stream
        step(0, 1, 5'd12, 32'hC0FFEE, 0, 0, 0, 12);
        @(posedge Clk);
        #2;
        bus.LdValid = 0;
        chk("t6_pre_reset_we", bus.WrEnable, 1'b1);
        Rst_n = 1'b0;
        #1;
        q.delete();
        chk("t6_rst_we", bus.WrEnable, 1'b0);
        chk("t6_rst_addr", bus.WrAddr, 5'd0);
        chk("t6_rst_data", bus.WrData, 32'd0);
        chk("t6_rst_pend", bus.QPending, 1'b0);
        chk("t6_rst_qdata", bus.QData, 32'd0);
        chk("t6_rst_count", bus.Count, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        idle(12);
        // randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(15) == 0, $urandom_range(1), 5'($urandom_range(7)), $urandom,
                 $urandom_range(1), 5'($urandom_range(7)), $urandom, 5'($urandom_range(7)));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
